data_proc_inc: RTL and testbench
================================

DATA_PROC_INC -- requirements
Module: data_proc_inc

Interface
REQ-001 Parameter DATA_WIDTH, default 512: stream data width in bits; SHALL be a multiple of LANE_WIDTH.
REQ-002 Parameter LANE_WIDTH, default 32: width of each independently processed unsigned lane.
REQ-003 Parameter INC_VALUE, default 1: unsigned constant added to every lane; SHALL fit in LANE_WIDTH bits.
REQ-004 Parameter OBUF_DEPTH, default 2: output buffer entries; SHALL be a power of two, minimum 2.
REQ-005 Port ap_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port ap_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port ap_start, input, 1: start request, sampled only in IDLE.
REQ-008 Port beat_count, input, 32: number of beats per call, latched on accepted ap_start.
REQ-009 Port ap_done, output, 1: one-cycle pulse when the call has fully completed.
REQ-010 Port ap_idle, output, 1: high only while in IDLE.
REQ-011 Port ap_ready, output, 1: one-cycle pulse when the last input beat of a call is accepted.
REQ-012 Port Input_1_TDATA, input, DATA_WIDTH: input stream data.
REQ-013 Port Input_1_TVALID / Input_1_TREADY, input / output, 1 each: input handshake.
REQ-014 Port Output_1_TDATA, output, DATA_WIDTH: processed stream data.
REQ-015 Port Output_1_TVALID / Output_1_TREADY, output / input, 1 each: output handshake.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE; exactly one state active.
REQ-017 IDLE: on ap_start=1, latch beat_count into remaining counter; go to RUN if nonzero, else go directly to DONE.
REQ-018 ap_start outside IDLE SHALL be ignored.
REQ-019 Input_1_TREADY = (state==RUN) && (registered occupancy < OBUF_DEPTH); SHALL not depend combinationally on Output_1_TREADY.
REQ-020 Accepted beat: every lane i SHALL become lane_i + INC_VALUE, mod 2^LANE_WIDTH (wrap-around), and be written to the buffer.
REQ-021 Each accept decrements remaining; the accept with remaining==1 pulses ap_ready in that same cycle and moves to DRAIN.
REQ-022 Latency: a beat accepted in cycle N SHALL appear on Output_1 with TVALID=1 no earlier than N+1, and at N+1 if the buffer is empty.
REQ-023 With Output_1_TREADY held high, throughput SHALL be one beat per cycle.
REQ-024 Output_1_TVALID = occupancy>0; TDATA SHALL remain stable while TVALID=1 and TREADY=0.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; order is strictly FIFO.
REQ-026 DRAIN: when occupancy reaches 0, go to DONE.
REQ-027 DONE: assert ap_done for exactly one cycle, then return to IDLE; ap_idle=0 during DONE.

Reset
REQ-028 ap_rst_n=0 SHALL immediately force IDLE, clear occupancy and counters, and drive ap_done=0, ap_ready=0, ap_idle=1, Input_1_TREADY=0, Output_1_TVALID=0, Output_1_TDATA=0.
REQ-029 Reset mid-call SHALL discard buffered beats and SHALL NOT produce ap_done or ap_ready.

Configuration
REQ-030 Macro DATA_PROC_SAT_EN defined: each lane add SHALL saturate at 2^LANE_WIDTH-1.
REQ-031 Macro DATA_PROC_SAT_EN undefined: lane add SHALL wrap per REQ-020.

Verification
REQ-032 beat_count=4, lanes=0..15, TREADY always 1 -> outputs lanes 1..16, 4 beats back-to-back, ap_ready on 4th accept, ap_done 2 cycles later.
REQ-033 beat_count=0, ap_start pulse -> no TREADY, ap_done one cycle after start, back to IDLE.
REQ-034 beat_count=8, Output_1_TREADY low 5 cycles -> Input_1_TREADY drops after 2 accepts, no data loss, TDATA stable, order preserved.
REQ-035 Lane value 0xFFFFFFFF -> output 0x00000000 without DATA_PROC_SAT_EN, 0xFFFFFFFF with it.
REQ-036 Reset asserted after 3 of 6 beats -> all outputs at reset values immediately; no ap_done; next call of 2 beats completes normally.
REQ-037 ap_start pulsed during RUN with different beat_count -> ignored; original count completes.

Source files
------------

// File: rtl/data_proc_inc.sv
// data_proc_inc: adds INC_VALUE to every lane of an AXI-Stream beat, with ap_ctrl call handshake and an output FIFO.
// Build option: define DATA_PROC_SAT_EN to saturate each lane add at its maximum instead of wrapping.
module data_proc_inc #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned INC_VALUE  = 1,
    parameter int unsigned OBUF_DEPTH = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic [31:0]           beat_count,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [DATA_WIDTH-1:0] Input_1_TDATA,
    input  logic                  Input_1_TVALID,
    output logic                  Input_1_TREADY,
    output logic [DATA_WIDTH-1:0] Output_1_TDATA,
    output logic                  Output_1_TVALID,
    input  logic                  Output_1_TREADY
);

    localparam int NUM_LANES = int'(DATA_WIDTH / LANE_WIDTH);
    localparam int unsigned PTR_W = $clog2(OBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [LANE_WIDTH-1:0] INC_LANE  = LANE_WIDTH'(INC_VALUE);
    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(OBUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [31:0]           r_remaining;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0] w_proc;
    logic                  w_push;
    logic                  w_pop;
`ifdef DATA_PROC_SAT_EN
    logic [LANE_WIDTH:0]   w_sum;
`endif

    // Input readiness looks only at registered occupancy, so there is no path from Output_1_TREADY.
    assign Input_1_TREADY  = (r_state == S_RUN) && (r_count < DEPTH_CNT);
    assign w_push          = Input_1_TVALID && Input_1_TREADY;
    assign Output_1_TVALID = (r_count != '0);
    assign w_pop           = Output_1_TVALID && Output_1_TREADY;
    assign w_count_next    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign Output_1_TDATA  = Output_1_TVALID ? r_mem[r_rd_ptr] : '0;

    assign ap_ready = w_push && (r_remaining == 32'd1);
    assign ap_done  = (r_state == S_DONE);
    assign ap_idle  = (r_state == S_IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        w_proc = '0;
`ifdef DATA_PROC_SAT_EN
        w_sum  = '0;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
`ifdef DATA_PROC_SAT_EN
            w_sum = {1'b0, Input_1_TDATA[i*LANE_WIDTH +: LANE_WIDTH]} + {1'b0, INC_LANE};
            w_proc[i*LANE_WIDTH +: LANE_WIDTH] = w_sum[LANE_WIDTH] ? '1 : w_sum[LANE_WIDTH-1:0];
`else
            w_proc[i*LANE_WIDTH +: LANE_WIDTH] = Input_1_TDATA[i*LANE_WIDTH +: LANE_WIDTH] + INC_LANE;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (ap_start) w_state_next = (beat_count != 32'd0) ? S_RUN : S_DONE;
            S_RUN:   if (w_push && (r_remaining == 32'd1)) w_state_next = S_DRAIN;
            // Leave DRAIN in the cycle the last beat is popped, not one cycle after.
            S_DRAIN: if (w_count_next == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if ((r_state == S_IDLE) && ap_start) r_remaining <= beat_count;
            else if (w_push)                     r_remaining <= r_remaining - 32'd1;
        end
    end

    // NOTE: storage is not reset; occupancy and pointers alone decide which entries are live.
    always_ff @(posedge ap_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_proc;
    end

endmodule

// File: tb/tb_data_proc_inc.sv
// Scoreboard bench for data_proc_inc: lane-arithmetic reference model, randomized data and output backpressure.
module tb_data_proc_inc;

    localparam int DW    = 512;
    localparam int LW    = 32;
    localparam int NL    = DW / LW;
    localparam int INC   = 1;
    localparam int DEPTH = 2;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic [31:0]   beat_count = '0;
    logic          ap_done, ap_idle, ap_ready;
    logic [DW-1:0] Input_1_TDATA = '0;
    logic          Input_1_TVALID = 1'b0;
    logic          Input_1_TREADY;
    logic [DW-1:0] Output_1_TDATA;
    logic          Output_1_TVALID;
    logic          Output_1_TREADY = 1'b1;

    data_proc_inc #(
        .DATA_WIDTH(DW), .LANE_WIDTH(LW), .INC_VALUE(INC), .OBUF_DEPTH(DEPTH)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .beat_count(beat_count),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .Input_1_TDATA(Input_1_TDATA), .Input_1_TVALID(Input_1_TVALID), .Input_1_TREADY(Input_1_TREADY),
        .Output_1_TDATA(Output_1_TDATA), .Output_1_TVALID(Output_1_TVALID), .Output_1_TREADY(Output_1_TREADY)
    );

    always #5 ap_clk = ~ap_clk;

    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    logic [DW-1:0] exp_q[$];
    int            acc_cycles[$];
    int            ready_cycles[$];
    int            done_cycles[$];
    int            out_cycles[$];
    bit            tready_seen = 1'b0;
    bit            hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic [DW-1:0] last_out = '0;
    bit            rand_ready_en = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: each unsigned lane plus INC, either wrapped modulo 2^32 or clamped at 2^32-1.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
        logic [DW-1:0]   r;
        longint unsigned s;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            s = 64'(d[i*LW +: LW]) + 64'(INC);
`ifdef DATA_PROC_SAT_EN
            if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`else
            s = s & 64'hFFFF_FFFF;
`endif
            r[i*LW +: LW] = s[LW-1:0];
        end
        return r;
    endfunction

    // Monitor: records handshakes, pushes expectations on input accept, pops and compares on output pop.
    always @(negedge ap_clk) begin
        logic [DW-1:0] exp;
        if (!ap_rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (Input_1_TREADY) tready_seen = 1'b1;
            if (Input_1_TVALID && Input_1_TREADY) begin
                exp_q.push_back(model(Input_1_TDATA));
                acc_cycles.push_back(cyc);
            end
            if (ap_ready) ready_cycles.push_back(cyc);
            if (ap_done)  done_cycles.push_back(cyc);
            if (hold_valid) begin
                check("tvalid_held", int'(Output_1_TVALID), 1);
                check_data("tdata_stable", Output_1_TDATA, hold_data);
            end
            if (Output_1_TVALID && Output_1_TREADY) begin
                check("sb_q_nonempty", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check_data("sb_data", Output_1_TDATA, exp);
                end
                out_cycles.push_back(cyc);
                last_out = Output_1_TDATA;
            end
            hold_valid = Output_1_TVALID && !Output_1_TREADY;
            hold_data  = Output_1_TDATA;
        end
    end

    always begin
        @(posedge ap_clk);
        #1;
        if (rand_ready_en) Output_1_TREADY = 1'($urandom_range(0, 1));
    end

    task automatic clear_rec();
        acc_cycles.delete();
        ready_cycles.delete();
        done_cycles.delete();
        out_cycles.delete();
        tready_seen = 1'b0;
    endtask

    task automatic start_call(input int n);
        @(posedge ap_clk);
        #1;
        ap_start   = 1'b1;
        beat_count = n;
        start_cyc  = cyc;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
    endtask

    // mode 0: lane i of beat b = NL*b+i; mode 1: random lanes; mode 2: all lanes at maximum.
    task automatic send_beats(input int n, input int mode);
        logic [DW-1:0] d;
        bit            got;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < NL; i++) begin
                if (mode == 0)      d[i*LW +: LW] = 32'(NL * b + i);
                else if (mode == 1) d[i*LW +: LW] = $urandom();
                else                d[i*LW +: LW] = 32'hFFFF_FFFF;
            end
            Input_1_TDATA  = d;
            Input_1_TVALID = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge ap_clk);
                if (Input_1_TREADY) got = 1'b1;
            end
            check("in_accept_timeout", int'(got), 1);
            @(posedge ap_clk);
            #1;
            if (!got) break;
        end
        Input_1_TVALID = 1'b0;
    endtask

    task automatic finish_call(input int n);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge ap_clk);
            if (ap_done) got = 1'b1;
        end
        check("done_timeout", int'(got), 1);
        if (got) check("idle_low_in_done", int'(ap_idle), 0);
        @(negedge ap_clk);
        check("done_one_cycle", int'(ap_done), 0);
        check("idle_after_done", int'(ap_idle), 1);
        check("accept_count", acc_cycles.size(), n);
        check("ready_count", ready_cycles.size(), (n > 0) ? 1 : 0);
        if (n > 0 && ready_cycles.size() == 1 && acc_cycles.size() == n)
            check("ready_on_last_accept", ready_cycles[0], acc_cycles[n-1]);
        check("done_count", done_cycles.size(), 1);
        check("out_count", out_cycles.size(), n);
        check("sb_empty", exp_q.size(), 0);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_ff;

        // Reset state
        #1;
        check("rst_idle", int'(ap_idle), 1);
        check("rst_done", int'(ap_done), 0);
        check("rst_ready", int'(ap_ready), 0);
        check("rst_in_tready", int'(Input_1_TREADY), 0);
        check("rst_out_tvalid", int'(Output_1_TVALID), 0);
        check_data("rst_out_tdata", Output_1_TDATA, '0);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        // Four back-to-back beats with lanes 0..15 onward
        clear_rec();
        start_call(4);
        send_beats(4, 0);
        finish_call(4);
        if (acc_cycles.size() == 4 && out_cycles.size() == 4 && ready_cycles.size() == 1 && done_cycles.size() == 1) begin
            check("accept_back_to_back", acc_cycles[3] - acc_cycles[0], 3);
            check("first_out_latency", out_cycles[0] - acc_cycles[0], 1);
            check("out_back_to_back", out_cycles[3] - out_cycles[0], 3);
            check("done_after_ready", done_cycles[0] - ready_cycles[0], 2);
        end

        // Lane at maximum value
        clear_rec();
        start_call(1);
        send_beats(1, 2);
        finish_call(1);
`ifdef DATA_PROC_SAT_EN
        exp_ff = '1;
`else
        exp_ff = '0;
`endif
        check_data("lane_max_add", last_out, exp_ff);

        // Zero-beat call
        clear_rec();
        start_call(0);
        finish_call(0);
        check("zero_no_tready", int'(tready_seen), 0);
        if (done_cycles.size() == 1) check("zero_done_latency", done_cycles[0] - start_cyc, 1);

        // Output stall: input readiness drops after two accepts
        clear_rec();
        Output_1_TREADY = 1'b0;
        fork
            begin
                start_call(8);
                send_beats(8, 1);
            end
            begin
                repeat (7) @(negedge ap_clk);
                check("stall_accepts", acc_cycles.size(), DEPTH);
                check("stall_in_tready", int'(Input_1_TREADY), 0);
                @(posedge ap_clk);
                #1;
                Output_1_TREADY = 1'b1;
            end
        join
        finish_call(8);

        // ap_start during RUN is ignored
        clear_rec();
        fork
            begin
                start_call(3);
                send_beats(3, 1);
            end
            begin
                repeat (3) @(posedge ap_clk);
                #1;
                ap_start   = 1'b1;
                beat_count = 32'd7;
                @(posedge ap_clk);
                #1;
                ap_start = 1'b0;
            end
        join
        finish_call(3);

        // Reset mid-call, then a normal call
        clear_rec();
        start_call(6);
        send_beats(3, 1);
        ap_rst_n = 1'b0;
        #1;
        check("midrst_idle", int'(ap_idle), 1);
        check("midrst_done", int'(ap_done), 0);
        check("midrst_ready", int'(ap_ready), 0);
        check("midrst_in_tready", int'(Input_1_TREADY), 0);
        check("midrst_out_tvalid", int'(Output_1_TVALID), 0);
        check_data("midrst_out_tdata", Output_1_TDATA, '0);
        exp_q.delete();
        repeat (2) @(posedge ap_clk);
        #1;
        check("midrst_no_done", done_cycles.size(), 0);
        check("midrst_no_ready", ready_cycles.size(), 0);
        ap_rst_n = 1'b1;
        clear_rec();
        start_call(2);
        send_beats(2, 1);
        finish_call(2);

        // Random calls under random backpressure
        rand_ready_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 10));
            clear_rec();
            start_call(n);
            send_beats(n, 1);
            finish_call(n);
        end
        rand_ready_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
